cpucr_prefetch: RTL and testbench

- Instruction-byte prefetch unit directly downstream of the CPUCR main memory.
- Drives the memory address bus in read-only mode and captures each returned byte together with its address.
- Buffers the bytes in a small FIFO for the decoder and handles jump/branch redirects by flushing the FIFO.
- Operand bytes are delivered in memory order (low byte first, e.g. 0x00,0x20 for address 0x2000). Word assembly is the decoder's job.

---
 rtl/cpucr_prefetch.sv | 105 ++++++++++
 tb/tb_cpucr_prefetch.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpucr_prefetch.sv
// Instruction-byte prefetch unit for the CPUCR core: reads main memory sequentially,
// queues {byte, address} pairs for the decoder and flushes the queue on redirects.
module cpucr_prefetch #(
    parameter int          DEPTH      = 4,
    parameter logic [15:0] RESET_ADDR = 16'h0000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    output logic [15:0]              Direccion,
    output logic                     LE,
    input  logic [7:0]               Datos,
    input  logic                     fetch_en,
    input  logic                     redirect,
    input  logic [15:0]              redirect_addr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_byte,
    output logic [15:0]              out_addr,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t          r_state;
    logic [15:0]     r_pc;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [7:0]      r_mem_byte [DEPTH];
    logic [15:0]     r_mem_addr [DEPTH];

    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

    // A redirect discards any transfer in its cycle, so it masks both push and pop.
    assign w_pop  = !w_empty && out_ready && !redirect;
    assign w_push = (r_state == FETCH) && fetch_en && !redirect && (!w_full || w_pop);

    // The address bus is the PC register itself, so it is always a registered value.
    assign Direccion = r_pc;
    assign LE        = 1'b1;
    assign out_valid = !w_empty;
    assign fill      = r_count;
    assign out_byte  = w_empty ? 8'h00  : r_mem_byte[r_rd_ptr];
    assign out_addr  = w_empty ? 16'h0000 : r_mem_addr[r_rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!reset_n) begin
            r_state  <= IDLE;
            r_pc     <= RESET_ADDR;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect) begin
            r_state  <= FLUSH;
            r_pc     <= redirect_addr;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_pc     <= r_pc + 16'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            case (r_state)
                IDLE:    if (fetch_en) r_state <= FETCH;
                FETCH:   if (!fetch_en) r_state <= IDLE;
                FLUSH:   r_state <= fetch_en ? FETCH : IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // NOTE: the storage array has no reset; an entry is only visible after it is
    // written, and the empty case forces the outputs to zero instead.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_byte[r_wr_ptr] <= Datos;
            r_mem_addr[r_wr_ptr] <= Direccion;
        end
    end

endmodule

// File: tb/tb_cpucr_prefetch.sv
// Directed bench for cpucr_prefetch: a 64 KiB combinational memory model drives Datos,
// and each scenario checks outputs 1 ns after the rising edge against hand-derived values.
module tb_cpucr_prefetch;

    logic        clk;
    logic        reset_n;
    logic [15:0] Direccion;
    logic        LE;
    logic [7:0]  Datos;
    logic        fetch_en;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic [15:0] out_addr;
    logic [2:0]  fill;

    logic [7:0]  mem [0:65535];

    int n_checks = 0;
    int n_errors = 0;

    cpucr_prefetch #(.DEPTH(4), .RESET_ADDR(16'h0000)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .Direccion     (Direccion),
        .LE            (LE),
        .Datos         (Datos),
        .fetch_en      (fetch_en),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_byte      (out_byte),
        .out_addr      (out_addr),
        .fill          (fill)
    );

    assign Datos = mem[Direccion];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic init_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'hC3;
        for (int i = 0; i < 6; i++) mem[i] = 8'(i + 1);
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        fetch_en      = 1'b0;
        redirect      = 1'b0;
        redirect_addr = 16'h0000;
        out_ready     = 1'b0;
        repeat (2) step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_fill",  32'(fill),      32'd0);
        check("rst_dir",   32'(Direccion), 32'h0000);
        check("rst_le",    32'(LE),        32'd1);
        check("rst_byte",  32'(out_byte),  32'h00);
        check("rst_addr",  32'(out_addr),  32'h0000);
        reset_n = 1'b1;
    endtask

    initial begin
        init_mem();
        do_reset();

        // Sequential fetch with a decoder that always accepts.
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        step();
        check("seq_first_valid", 32'(out_valid), 32'd0);
        check("seq_first_dir",   32'(Direccion), 32'h0000);
        for (int k = 0; k < 6; k++) begin
            step();
            check("seq_valid", 32'(out_valid), 32'd1);
            check("seq_byte",  32'(out_byte),  32'(k + 1));
            check("seq_addr",  32'(out_addr),  32'(k));
            check("seq_dir",   32'(Direccion), 32'(k + 1));
            check("seq_fill",  32'(fill),      32'd1);
            check("seq_le",    32'(LE),        32'd1);
        end

        // Backpressure until full, one simultaneous push/pop, then drain in order.
        do_reset();
        fetch_en = 1'b1;
        repeat (6) step();
        check("full_fill", 32'(fill),      32'd4);
        check("full_dir",  32'(Direccion), 32'h0004);
        check("full_byte", 32'(out_byte),  32'h01);
        step();
        check("full_hold_fill", 32'(fill),      32'd4);
        check("full_hold_dir",  32'(Direccion), 32'h0004);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("pp_fill", 32'(fill),      32'd4);
        check("pp_byte", 32'(out_byte),  32'h02);
        check("pp_addr", 32'(out_addr),  32'h0001);
        check("pp_dir",  32'(Direccion), 32'h0005);
        step();
        check("pp_stable_byte", 32'(out_byte),  32'h02);
        check("pp_stable_fill", 32'(fill),      32'd4);
        check("pp_stable_dir",  32'(Direccion), 32'h0005);
        fetch_en  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("drain_byte", 32'(out_byte), 32'(k + 3));
            check("drain_addr", 32'(out_addr), 32'(k + 2));
            check("drain_fill", 32'(fill),     32'(3 - k));
        end
        step();
        check("drain_empty_valid", 32'(out_valid), 32'd0);
        check("drain_empty_fill",  32'(fill),      32'd0);
        check("drain_dir",         32'(Direccion), 32'h0005);

        // Redirect with three bytes buffered; the pop offered on that edge is discarded.
        do_reset();
        mem[16'h2000] = 8'hAA;
        mem[16'h2001] = 8'hBB;
        fetch_en = 1'b1;
        repeat (4) step();
        check("redir_pre_fill", 32'(fill), 32'd3);
        redirect      = 1'b1;
        redirect_addr = 16'h2000;
        out_ready     = 1'b1;
        step();
        redirect  = 1'b0;
        out_ready = 1'b0;
        check("redir_fill",  32'(fill),      32'd0);
        check("redir_valid", 32'(out_valid), 32'd0);
        check("redir_dir",   32'(Direccion), 32'h2000);
        step();
        check("bubble_valid", 32'(out_valid), 32'd0);
        check("bubble_dir",   32'(Direccion), 32'h2000);
        step();
        check("redir_byte", 32'(out_byte),  32'hAA);
        check("redir_addr", 32'(out_addr),  32'h2000);
        check("redir_next", 32'(Direccion), 32'h2001);

        // Redirect twice back to back (second lands in FLUSH), then wrap past FFFF.
        mem[16'hFFFE] = 8'h11;
        mem[16'hFFFF] = 8'h22;
        mem[16'h0000] = 8'h33;
        redirect      = 1'b1;
        redirect_addr = 16'h1234;
        step();
        check("rr1_dir", 32'(Direccion), 32'h1234);
        redirect_addr = 16'hFFFE;
        step();
        redirect  = 1'b0;
        out_ready = 1'b1;
        check("rr2_dir",  32'(Direccion), 32'hFFFE);
        check("rr2_fill", 32'(fill),      32'd0);
        step();
        check("wrap_bubble", 32'(out_valid), 32'd0);
        step();
        check("wrap_b0", 32'(out_byte), 32'h11);
        check("wrap_a0", 32'(out_addr), 32'hFFFE);
        step();
        check("wrap_b1", 32'(out_byte),  32'h22);
        check("wrap_a1", 32'(out_addr),  32'hFFFF);
        check("wrap_d1", 32'(Direccion), 32'h0000);
        step();
        check("wrap_b2", 32'(out_byte),  32'h33);
        check("wrap_a2", 32'(out_addr),  32'h0000);
        check("wrap_d2", 32'(Direccion), 32'h0001);
        mem[16'h0000] = 8'h01;

        // fetch_en gating: two bytes buffered, drain with PC frozen, then resume.
        do_reset();
        fetch_en = 1'b1;
        repeat (3) step();
        check("gate_fill", 32'(fill),      32'd2);
        check("gate_dir",  32'(Direccion), 32'h0002);
        fetch_en  = 1'b0;
        out_ready = 1'b1;
        step();
        check("gate_d1_byte", 32'(out_byte),  32'h02);
        check("gate_d1_fill", 32'(fill),      32'd1);
        check("gate_d1_dir",  32'(Direccion), 32'h0002);
        step();
        check("gate_d2_fill", 32'(fill),      32'd0);
        check("gate_d2_dir",  32'(Direccion), 32'h0002);
        step();
        check("gate_empty_pop_fill", 32'(fill),      32'd0);
        check("gate_idle_dir",       32'(Direccion), 32'h0002);
        fetch_en = 1'b1;
        step();
        check("resume_wait", 32'(out_valid), 32'd0);
        step();
        check("resume_addr", 32'(out_addr), 32'h0002);
        check("resume_byte", 32'(out_byte), 32'h03);

        // Asynchronous reset asserted between edges mid-stream.
        do_reset();
        fetch_en = 1'b1;
        repeat (4) step();
        check("ar_pre_fill", 32'(fill),      32'd3);
        check("ar_pre_dir",  32'(Direccion), 32'h0003);
        #2 reset_n = 1'b0;
        #1;
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_fill",  32'(fill),      32'd0);
        check("ar_dir",   32'(Direccion), 32'h0000);
        check("ar_byte",  32'(out_byte),  32'h00);
        #1 reset_n = 1'b1;
        out_ready = 1'b1;
        step();
        check("ar_restart_wait", 32'(out_valid), 32'd0);
        step();
        check("ar_restart_addr", 32'(out_addr), 32'h0000);
        check("ar_restart_byte", 32'(out_byte), 32'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
